// File: rtl/mdu_seq.sv
// mdu_seq: sequential 32-bit MIPS multiply/divide unit with HI/LO registers
module mdu_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_in1,
    input  logic [31:0] i_in2,
    input  logic        i_flush,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_hi, r_lo;
    logic [63:0] r_acc;
    logic        r_nq, r_nr;
    logic        w_go, w_sgn;
    logic [31:0] w_m1, w_m2, w_fhi, w_flo;
    logic [32:0] w_add;
    logic [33:0] w_diff;
    logic [63:0] w_mul, w_div, w_pneg;
    assign w_go   = (r_state == IDLE) && i_start && !i_flush;
    assign w_sgn  = !i_op[0];
    assign w_m1   = (w_sgn && i_in1[31]) ? -i_in1 : i_in1;
    assign w_m2   = (w_sgn && i_in2[31]) ? -i_in2 : i_in2;
    assign w_add  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_mul  = {w_add, r_acc[31:1]};
    // remainder is widened to 33 bits so the shifted-in bit never overflows
    assign w_diff = {1'b0, r_acc[63:31]} - {2'b00, r_a};
    assign w_div  = w_diff[33] ? {r_acc[62:0], 1'b0} : {w_diff[31:0], r_acc[30:0], 1'b1};
    assign w_pneg = -r_acc;
    assign w_fhi  = r_op[1] ? (r_nr ? -r_acc[63:32] : r_acc[63:32])
                            : (r_nq ? w_pneg[63:32] : r_acc[63:32]);
    assign w_flo  = r_nq ? (r_op[1] ? -r_acc[31:0] : w_pneg[31:0]) : r_acc[31:0];
    assign o_busy = (r_state != IDLE);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    always_comb begin
        w_next = r_state;
        if (i_flush)
            w_next = IDLE;
        else if (r_state == IDLE)
            w_next = i_start ? CALC : IDLE;
        else if (r_state == CALC)
            w_next = (r_cnt == 5'd31) ? FIX : CALC;
        else
            w_next = IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= 5'd0;
            r_op  <= 2'd0;
            r_a   <= 32'd0;
            r_acc <= 64'd0;
            r_nq  <= 1'b0;
            r_nr  <= 1'b0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_go) begin
                r_cnt <= 5'd0;
                r_op  <= i_op;
                r_a   <= i_op[1] ? w_m2 : w_m1;
                r_acc <= {32'd0, i_op[1] ? w_m1 : w_m2};
                // divide by zero keeps the all-ones quotient unsigned; the remainder sign restores in1
                r_nq  <= w_sgn && (i_in1[31] ^ i_in2[31]) && !(i_op[1] && i_in2 == 32'd0);
                r_nr  <= w_sgn && i_in1[31];
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + 5'd1;
                r_acc <= r_op[1] ? w_div : w_mul;
            end
            if (r_state == FIX && !i_flush) begin
                r_hi <= w_fhi;
                r_lo <= w_flo;
            end else if (r_state == IDLE && !i_start) begin
                if (i_hi_we) r_hi <= i_wdata;
                if (i_lo_we) r_lo <= i_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and random scoreboard checks of mdu_seq
module tb_mdu_seq;
    logic        clk = 0, reset = 1, start = 0, flush = 0, hi_we = 0, lo_we = 0;
    logic [1:0]  op = 0;
    logic [31:0] in1 = 0, in2 = 0, wdata = 0;
    logic        busy;
    logic [31:0] hi, lo;
    logic [63:0] q[$];
    logic [63:0] e;
    int          total = 0, bad = 0, n = 0;

    mdu_seq dut (.i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_in1(in1),
                 .i_in2(in2), .i_flush(flush), .i_hi_we(hi_we), .i_lo_we(lo_we),
                 .i_wdata(wdata), .o_busy(busy), .o_hi(hi), .o_lo(lo));

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = {{32{a[31]}}, a};
        longint sb = {{32{b[31]}}, b};
        longint ua = {32'd0, a};
        longint ub = {32'd0, b};
        longint qq, rr;
        if (o == 2'd0) return 64'(sa * sb);
        if (o == 2'd1) return 64'(ua * ub);
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        qq = o[0] ? ua / ub : sa / sb;
        rr = o[0] ? ua % ub : sa % sb;
        return {rr[31:0], qq[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit push);
        @(negedge clk);
        start = 1; op = o; in1 = a; in2 = b;
        if (push) q.push_back(exp);
        @(negedge clk);
        start = 0;
        n = 1;
    endtask

    task automatic advance_to(input int k);
        while (n < k) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic complete(input string tag);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busycyc"}, 64'(n - 1), 64'd33);
        e = (q.size() != 0) ? q.pop_front() : 64'hX;
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 0;

        launch(2'd0, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1); complete("mult");
        launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1); complete("multu");
        launch(2'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1); complete("div_neg");
        launch(2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1); complete("div_ovf");
        launch(2'd3, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1); complete("divu_z");
        launch(2'd2, 32'hFFFFFF9C, 32'd0, 64'hFFFFFF9C_FFFFFFFF, 1); complete("div_z");

        @(negedge clk); hi_we = 1; wdata = 32'h1234;
        @(negedge clk); hi_we = 0; lo_we = 1; wdata = 32'h5678;
        @(negedge clk); lo_we = 0;
        chk("mt_hilo", {hi, lo}, 64'h00001234_00005678);

        launch(2'd1, 32'd2, 32'd3, 64'd6, 0);
        hi_we = 1; lo_we = 1; wdata = 32'hDEAD;
        advance_to(10);
        hi_we = 0; lo_we = 0; flush = 1;
        @(negedge clk); flush = 0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h00001234_00005678);

        @(negedge clk); start = 1; hi_we = 1; wdata = 32'hBEEF; op = 2'd1; in1 = 1; in2 = 1;
        @(negedge clk); start = 0; hi_we = 0; flush = 1;
        @(negedge clk); flush = 0;
        chk("startwe_hi", {32'd0, hi}, 64'h1234);

        launch(2'd0, 32'd7, 32'd9, 64'd0, 0);
        advance_to(33);
        flush = 1;
        @(negedge clk); flush = 0;
        chk("flushfix_busy", {63'd0, busy}, 64'd0);
        chk("flushfix_hilo", {hi, lo}, 64'h00001234_00005678);

        @(negedge clk); start = 1; flush = 1; op = 2'd1; in1 = 4; in2 = 4;
        @(negedge clk); start = 0; flush = 0;
        chk("flushstart_busy", {63'd0, busy}, 64'd0);

        launch(2'd1, 32'd7, 32'd6, 64'd42, 1);
        advance_to(5);
        start = 1; op = 2'd3; in1 = 32'd1; in2 = 32'd1;
        @(negedge clk); n++; start = 0;
        complete("startbusy");
        repeat (3) @(negedge clk);
        chk("nosecond_busy", {63'd0, busy}, 64'd0);

        launch(2'd1, 32'd5, 32'd5, 64'd0, 0);
        advance_to(20);
        reset = 1;
        @(negedge clk); reset = 0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        launch(2'd3, 32'd9, 32'd4, 64'h00000001_00000002, 1); complete("divu94");

        for (int i = 0; i < 8; i++) begin
            ro = 2'(i);
            ra = $urandom;
            rb = (i == 6) ? 32'd0 : ((i > 3) ? 32'($urandom_range(1, 5000)) : $urandom);
            if (i == 7) rb = -rb;
            launch(ro, ra, rb, model(ro, ra, rb), 1);
            complete($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
